// File: rtl/float32_pkg.sv
// Shared float32 definitions: driver FSM states, special encodings and
// small classification helpers used by the accumulation driver.
package float32_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND_A = 3'd1,
    S_SEND_B = 3'd2,
    S_WAIT_Z = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == FP32_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  // Zero of either sign.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/float32_accum_driver.sv
// Reduces a valid/ready stream of float32 values (delimited by in_last) into
// one running sum per vector by driving a float32 adder over its stb/ack
// A/B/Z handshake. One adder operation is in flight at a time; summation is
// strictly left to right. The first element of a vector loads the
// accumulator directly, so a single-element vector passes bit-exact.
//
// Build option FP_ACC_ZERO_SKIP_EN: when defined, a zero element that would
// leave the accumulator bit-identical is counted but not sent to the adder.
module float32_accum_driver
  import float32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      sum_out,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [31:0]      add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [31:0]      add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [31:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [31:0]      acc;      // running sum, also the A operand
  logic [31:0]      opb;      // pending B operand
  logic [CNT_W-1:0] cnt;
  logic             last_q;   // pending B operand closes the vector
  logic             has_acc;  // accumulator holds the vector's first element
  logic             run_q;    // low for the first cycle out of reset
  logic             skip;
  logic [CNT_W-1:0] cnt_inc;

  // Operand and result buses come straight from registers, so they are stable
  // for as long as the matching strobe is held.
  assign add_a     = acc;
  assign add_b     = opb;
  assign sum_out   = acc;
  assign sum_count = cnt;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef FP_ACC_ZERO_SKIP_EN
  // Adding +/-0 returns acc unchanged except for a NaN acc (payload may be
  // quietened) and -0 + +0 (gives +0); those still go through the adder.
  assign skip = is_zero(in_data) && !is_nan(acc) &&
                !((acc == FP32_NEG_ZERO) && (in_data == 32'h0000_0000));
`else
  assign skip = 1'b0;
`endif

  // State register.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    add_a_stb = 1'b0;
    add_b_stb = 1'b0;
    add_z_ack = 1'b0;
    sum_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = run_q;
        if (in_valid && run_q) begin
          if (!has_acc || skip) state_nxt = in_last ? S_EMIT : S_IDLE;
          else                  state_nxt = S_SEND_A;
        end
      end
      S_SEND_A: begin
        add_a_stb = 1'b1;
        if (add_a_ack) state_nxt = S_SEND_B;
      end
      S_SEND_B: begin
        add_b_stb = 1'b1;
        if (add_b_ack) state_nxt = S_WAIT_Z;
      end
      S_WAIT_Z: begin
        add_z_ack = 1'b1;
        if (add_z_stb) state_nxt = last_q ? S_EMIT : S_IDLE;
      end
      S_EMIT: begin
        sum_valid = 1'b1;
        if (sum_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, pending operand and element count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= 32'h0;
      opb     <= 32'h0;
      cnt     <= '0;
      last_q  <= 1'b0;
      has_acc <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (in_valid && in_ready) begin
        if (!has_acc) begin
          acc     <= in_data;
          cnt     <= CNT_W'(1);
          has_acc <= 1'b1;
        end else begin
          cnt <= cnt_inc;
          if (!skip) begin
            opb    <= in_data;
            last_q <= in_last;
          end
        end
      end
      if (add_z_stb && add_z_ack) acc <= add_z;
      if (sum_valid && sum_ready) has_acc <= 1'b0;
    end
  end

endmodule
